// File: rtl/x_fifo_pkg.sv
// x_fifo_pkg: shared sizing constants for the 32-deep distributed-RAM FIFO
package x_fifo_pkg;
  localparam int DEPTH = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W = 6;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/x_ramd32.sv
// x_ramd32: 32x1 dual-port RAM, synchronous write, asynchronous read
module x_ramd32
  import x_fifo_pkg::*;
(
  input  logic  CLK,
  input  logic  WE,
  input  logic  I,
  input  addr_t WADR,
  input  addr_t RADR,
  output logic  O
);
  logic mem_q [DEPTH];
  always_ff @(posedge CLK)
    if (WE) mem_q[WADR] <= I;
  assign O = mem_q[RADR];
endmodule

// File: rtl/x_fifo32.sv
// x_fifo32: 32-entry first-word-fall-through FIFO over per-bit distributed RAM
module x_fifo32
  import x_fifo_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] O,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [CNT_W-1:0] COUNT,
  output logic             FULL,
  output logic             EMPTY
);
  addr_t wptr_q, wptr_d, rptr_q, rptr_d;
  cnt_t cnt_q, cnt_d;
  logic push, pop;
  always_comb begin
    FULL = cnt_q == CNT_W'(DEPTH);
    EMPTY = cnt_q == '0;
    I_READY = !FULL;
    O_VALID = !EMPTY;
    COUNT = cnt_q;
    push = I_VALID && I_READY;
    pop = O_VALID && O_READY;
    wptr_d = wptr_q + ADDR_W'(push);
    rptr_d = rptr_q + ADDR_W'(pop);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end
  always_ff @(posedge CLK)
    if (RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
    end
  // RAM is never cleared; equal pointers after reset hide stale words
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    x_ramd32 u_ram (
      .CLK (CLK),
      .WE  (push),
      .I   (I[g]),
      .WADR(wptr_q),
      .RADR(rptr_q),
      .O   (O[g])
    );
  end
endmodule

// File: tb/tb_x_fifo32.sv
// tb_x_fifo32: directed and random checks of x_fifo32 against a queue model
module tb_x_fifo32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] i_data = '0;
  logic i_valid = 1'b0;
  logic i_ready;
  logic [7:0] o_data;
  logic o_valid;
  logic o_ready = 1'b0;
  logic [5:0] count;
  logic full, empty;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q[$];

  x_fifo32 #(.WIDTH(8)) dut (
    .CLK    (clk),
    .RST    (rst),
    .I      (i_data),
    .I_VALID(i_valid),
    .I_READY(i_ready),
    .O      (o_data),
    .O_VALID(o_valid),
    .O_READY(o_ready),
    .COUNT  (count),
    .FULL   (full),
    .EMPTY  (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("count", int'(count), q.size());
    chk("full", int'(full), int'(q.size() == 32));
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("i_ready", int'(i_ready), int'(q.size() != 32));
    chk("o_valid", int'(o_valid), int'(q.size() != 0));
    if (q.size() != 0) chk("head", int'(o_data), int'(q[0]));
  endtask

  // one cycle: check current state, apply inputs, advance model on the edge
  task automatic step(input logic rv, input logic vi, input logic [7:0] d, input logic orr);
    bit do_push, do_pop;
    check_outputs();
    rst = rv;
    i_valid = vi;
    i_data = d;
    o_ready = orr;
    do_push = vi && q.size() < 32;
    do_pop = orr && q.size() > 0;
    @(posedge clk);
    if (rv) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    // fill with 0x00..0x1F, then a refused 0xAA
    for (int k = 0; k < 32; k++) step(1'b0, 1'b1, 8'(k), 1'b0);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 32);
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    // drain, expecting 0x00..0x1F
    for (int k = 0; k < 32; k++) begin
      chk("drain_seq", int'(o_data), k);
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("drain_empty", int'(empty), 1);
    chk("drain_ovalid", int'(o_valid), 0);
    // full with simultaneous push and pop: pop only
    for (int k = 0; k < 32; k++) step(1'b0, 1'b1, 8'(k + 8'h80), 1'b0);
    step(1'b0, 1'b1, 8'h55, 1'b1);
    chk("full_pp_count", int'(count), 31);
    chk("full_pp_iready", int'(i_ready), 1);
    for (int k = 0; k < 31; k++) step(1'b0, 1'b0, 8'h00, 1'b1);
    // empty with simultaneous push and pop: push only
    step(1'b0, 1'b1, 8'h3C, 1'b1);
    chk("empty_pp_count", int'(count), 1);
    chk("empty_pp_head", int'(o_data), 8'h3C);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("empty_pp_drained", int'(empty), 1);
    // wrap with occupancy held at 3
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'(k), 1'b0);
    for (int k = 3; k < 100; k++) begin
      chk("wrap_count", int'(count), 3);
      chk("wrap_head", int'(o_data), k - 3);
      step(1'b0, 1'b1, 8'(k), 1'b1);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00, 1'b1);
    // mid-stream reset with push and pop active
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 8'(k + 8'h40), 1'b0);
    chk("pre_rst_count", int'(count), 10);
    step(1'b1, 1'b1, 8'hEE, 1'b1);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);
    step(1'b0, 1'b1, 8'h77, 1'b0);
    chk("post_rst_head", int'(o_data), 8'h77);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    // random traffic with biased fill/drain phases and rare resets
    for (int k = 0; k < 3000; k++) begin
      int bias;
      bias = (k / 300) % 2 == 0 ? 75 : 25;
      step($urandom_range(999) == 0, $urandom_range(99) < bias, 8'($urandom), $urandom_range(99) >= bias);
    end
    check_outputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/x_fifo32.md
X_FIFO32 -- requirements
Module: x_fifo32

Interface
REQ-001 Parameter WIDTH, default 1, data width in bits (1..16).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; synchronous and active-high.
REQ-004 I  input  WIDTH  write data.
REQ-005 I_VALID  input  1  write request.
REQ-006 I_READY  output  1  write accepted when I_VALID and I_READY are both high.
REQ-007 O  output  WIDTH  read data, head of queue (first-word-fall-through).
REQ-008 O_VALID  output  1  O holds valid head entry.
REQ-009 O_READY  input  1  read consume; pop occurs when O_VALID and O_READY are both high.
REQ-010 COUNT  output  6  number of stored entries, 0..32.
REQ-011 FULL  output  1  COUNT == 32.
REQ-012 EMPTY  output  1  COUNT == 0.

Function
REQ-013 Storage SHALL be 32 entries x WIDTH, one 32x1 dual-port distributed RAM slice per data bit: synchronous write, asynchronous read at an independent read address.
REQ-014 Write pointer WPTR and read pointer RPTR SHALL be 5 bits, each incrementing by 1 per push or pop respectively and wrapping 31 -> 0.
REQ-015 Push: I_VALID & I_READY writes I to RAM[WPTR] at the clock edge; WPTR increments that edge.
REQ-016 Pop: O_VALID & O_READY increments RPTR that edge; no other side effect.
REQ-017 O SHALL equal RAM[RPTR] combinationally; O is don't-care when O_VALID is low.
REQ-018 I_READY = !FULL; O_VALID = !EMPTY; FULL and EMPTY derived combinationally from COUNT.
REQ-019 COUNT next = COUNT + push - pop; simultaneous push and pop leave COUNT unchanged.
REQ-020 Full with O_READY high and I_VALID high: pop only, push refused (no write-through bypass); next cycle COUNT = 31, I_READY = 1.
REQ-021 Empty with I_VALID high and O_READY high: push only, no pop; written word appears on O with O_VALID = 1 one cycle after the write edge.
REQ-022 Latency: push-to-O_VALID is exactly 1 cycle when empty; no throughput bubble, one push and one pop per cycle sustained when 0 < COUNT < 32.
REQ-023 FIFO ordering SHALL be strict; data read equals data written, in order, across pointer wrap.

Reset
REQ-024 RST high at a clock edge: WPTR = 0, RPTR = 0, COUNT = 0, overriding any push or pop in that cycle.
REQ-025 Outputs after reset: COUNT = 0, EMPTY = 1, FULL = 0, O_VALID = 0, I_READY = 1.
REQ-026 RAM contents SHALL NOT be cleared by reset; stale data is unreachable because the pointers are equal.
REQ-027 Reset asserted mid-stream discards all stored entries; first push after reset is read back first.

Structure
REQ-028 Shared package x_fifo_pkg holds constants DEPTH = 32, ADDR_W = 5, CNT_W = 6.
REQ-029 One sub-module x_ramd32: 32x1 dual-port RAM (CLK, WE, I, WADR[4:0], RADR[4:0], O), instantiated WIDTH times via generate.
REQ-030 Pointer, count and handshake logic SHALL reside in x_fifo32 itself; no further sub-modules.

Verification
REQ-031 Reset then fill: WIDTH = 8, push 0x00..0x1F on 32 consecutive cycles, O_READY = 0 -> FULL = 1 and COUNT = 32 after the 32nd edge, I_READY = 0; a 33rd push of 0xAA is not stored.
REQ-032 Drain after fill: O_READY = 1 for 32 cycles -> O reads 0x00..0x1F in order, EMPTY = 1 after the final pop, O_VALID = 0.
REQ-033 Wrap: push/pop 100 sequential values with occupancy kept at 3 -> output sequence identical to input, COUNT constant at 3 during steady state, pointers wrap 3 times without loss.
REQ-034 Full + simultaneous push/pop: COUNT = 32, I_VALID = 1 with I = 0x55, O_READY = 1 -> head popped, 0x55 not written, COUNT = 31 next cycle.
REQ-035 Empty + simultaneous push/pop: COUNT = 0, push 0x3C with O_READY = 1 -> COUNT = 1, O = 0x3C, O_VALID = 1 next cycle; popped on the following cycle.
REQ-036 Mid-stream reset: COUNT = 10, assert RST for 1 cycle with push and pop active -> COUNT = 0, EMPTY = 1; subsequent push 0x77 is read out first.
